// File: rtl/mux_scan_sel.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_sel
// Description : Channel multiplexer with manual single-sample and auto-scan
//               modes, settle counter and valid/ready output handshake.
//               Optional channel mask enabled by defining MUX_SCAN_MASK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_scan_sel #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 16,
   parameter int SCAN_DIV = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [CHANNELS*WIDTH-1:0]     data_in,
   input  logic [$clog2(CHANNELS)-1:0]   sel_in,
   input  logic                          mode,
   input  logic                          start,
`ifdef MUX_SCAN_MASK_EN
   input  logic [CHANNELS-1:0]           ch_mask,
`endif
   output logic [WIDTH-1:0]              out_data,
   output logic [$clog2(CHANNELS)-1:0]   out_ch,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          busy,
   output logic                          err
);
   localparam int c_sw   = $clog2(CHANNELS);
   localparam int c_cw   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int c_npad = 1 << c_sw;
   localparam logic [c_cw-1:0] c_cnt_load = c_cw'(SCAN_DIV - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, HOLD = 2'd2} state_t;

   state_t              r_state, w_state_nxt;
   logic [c_sw-1:0]     r_idx, w_idx_nxt;
   logic [c_cw-1:0]     r_cnt, w_cnt_nxt;
   logic                r_manual, w_manual_nxt;
   logic [WIDTH-1:0]    r_out_data, w_out_data_nxt;
   logic [c_sw-1:0]     r_out_ch, w_out_ch_nxt;
   logic                r_out_valid, w_out_valid_nxt;
   logic                r_err, w_err_nxt;

   logic [CHANNELS-1:0] w_mask;
   logic [c_npad-1:0]   w_mask_pad;
   logic [WIDTH-1:0]    w_ch [c_npad];
   logic                w_sel_legal;
   logic                w_first_found, w_next_found;
   logic [c_sw-1:0]     w_first_idx, w_next_idx;

`ifdef MUX_SCAN_MASK_EN
   assign w_mask = ch_mask;
`else
   assign w_mask = '1;
`endif

   // Padding to a power of two makes out-of-range selects read as disabled.
   assign w_mask_pad  = c_npad'(w_mask);
   assign w_sel_legal = w_mask_pad[sel_in];

   genvar g;
   generate
      for (g = 0; g < c_npad; g++) begin : g_unpack
         if (g < CHANNELS) begin : g_real
            assign w_ch[g] = data_in[g*WIDTH +: WIDTH];
         end else begin : g_pad
            assign w_ch[g] = '0;
         end
      end
   endgenerate

   // Descending loop so the lowest qualifying channel wins.
   always_comb begin
      w_first_found = 1'b0;
      w_first_idx   = '0;
      w_next_found  = 1'b0;
      w_next_idx    = '0;
      for (int k = CHANNELS - 1; k >= 0; k--) begin
         if (w_mask[k]) begin
            w_first_found = 1'b1;
            w_first_idx   = c_sw'(k);
         end
         if (w_mask[k] && (k > int'(r_out_ch))) begin
            w_next_found = 1'b1;
            w_next_idx   = c_sw'(k);
         end
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_idx_nxt       = r_idx;
      w_cnt_nxt       = r_cnt;
      w_manual_nxt    = r_manual;
      w_out_data_nxt  = r_out_data;
      w_out_ch_nxt    = r_out_ch;
      w_out_valid_nxt = r_out_valid;
      w_err_nxt       = 1'b0;
      case (r_state)
         IDLE: begin
            if (start && !mode) begin
               if (w_sel_legal) begin
                  w_out_data_nxt  = w_ch[sel_in];
                  w_out_ch_nxt    = sel_in;
                  w_out_valid_nxt = 1'b1;
                  w_manual_nxt    = 1'b1;
                  w_state_nxt     = HOLD;
               end else begin
                  w_err_nxt = 1'b1;
               end
            end else if (start && mode && w_first_found) begin
               w_idx_nxt    = w_first_idx;
               w_cnt_nxt    = c_cnt_load;
               w_manual_nxt = 1'b0;
               w_state_nxt  = SCAN;
            end
         end
         SCAN: begin
            if (r_cnt == '0) begin
               w_out_data_nxt  = w_ch[r_idx];
               w_out_ch_nxt    = r_idx;
               w_out_valid_nxt = 1'b1;
               w_state_nxt     = HOLD;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         HOLD: begin
            if (r_out_valid && out_ready) begin
               w_out_valid_nxt = 1'b0;
               if (r_manual || !w_next_found) begin
                  w_state_nxt = IDLE;
               end else begin
                  w_idx_nxt   = w_next_idx;
                  w_cnt_nxt   = c_cnt_load;
                  w_state_nxt = SCAN;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_idx       <= '0;
         r_cnt       <= '0;
         r_manual    <= 1'b0;
         r_out_data  <= '0;
         r_out_ch    <= '0;
         r_out_valid <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_idx       <= w_idx_nxt;
         r_cnt       <= w_cnt_nxt;
         r_manual    <= w_manual_nxt;
         r_out_data  <= w_out_data_nxt;
         r_out_ch    <= w_out_ch_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_err       <= w_err_nxt;
      end
   end

   assign out_data  = r_out_data;
   assign out_ch    = r_out_ch;
   assign out_valid = r_out_valid;
   assign busy      = (r_state != IDLE);
   assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_sel.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_scan_sel
// Description : Directed self-checking bench for mux_scan_sel (default and
//               12-channel instances; mask scenario under MUX_SCAN_MASK_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_scan_sel;
   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic [127:0] data_in;
   logic [3:0]   sel_in;
   logic         mode, start, out_ready;
   logic [7:0]   out_data;
   logic [3:0]   out_ch;
   logic         out_valid, busy, err;
   logic [3:0]   sel12;
   logic         start12;
   logic [7:0]   out_data12;
   logic [3:0]   out_ch12;
   logic         out_valid12, busy12, err12;
`ifdef MUX_SCAN_MASK_EN
   logic [15:0]  ch_mask = '1;
   logic [11:0]  ch_mask12 = '1;
`endif
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mux_scan_sel #(.WIDTH(8), .CHANNELS(16), .SCAN_DIV(4)) dut (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .sel_in(sel_in),
      .mode(mode), .start(start),
`ifdef MUX_SCAN_MASK_EN
      .ch_mask(ch_mask),
`endif
      .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
      .out_ready(out_ready), .busy(busy), .err(err));

   mux_scan_sel #(.WIDTH(8), .CHANNELS(12), .SCAN_DIV(4)) dut12 (
      .clk(clk), .rst_n(rst_n), .data_in(data_in[95:0]), .sel_in(sel12),
      .mode(mode), .start(start12),
`ifdef MUX_SCAN_MASK_EN
      .ch_mask(ch_mask12),
`endif
      .out_data(out_data12), .out_ch(out_ch12), .out_valid(out_valid12),
      .out_ready(out_ready), .busy(busy12), .err(err12));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_pattern(input logic [7:0] base);
      for (int k = 0; k < 16; k++) data_in[k*8 +: 8] = base + 8'(k);
   endtask

   task automatic do_reset();
      start = 0; start12 = 0; mode = 0; sel_in = 0; sel12 = 0; out_ready = 0;
      rst_n = 0;
      repeat (2) step();
      rst_n = 1;
   endtask

   task automatic test_reset();
      start = 0; start12 = 0; mode = 0; sel_in = 0; sel12 = 0; out_ready = 0;
      set_pattern(8'hA0);
      #2 rst_n = 0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || out_data !== 8'h00 || out_ch !== 4'h0) begin
         errors++;
         $display("FAIL reset_state: valid=%b busy=%b err=%b data=%h ch=%0d expected all zero", out_valid, busy, err, out_data, out_ch);
      end
      checks++;
      if (out_valid12 !== 1'b0 || busy12 !== 1'b0 || err12 !== 1'b0) begin
         errors++;
         $display("FAIL reset_state12: valid=%b busy=%b err=%b expected 0", out_valid12, busy12, err12);
      end
      repeat (2) step();
      rst_n = 1;
   endtask

   task automatic test_manual();
      set_pattern(8'hA0);
      out_ready = 1; mode = 0; sel_in = 5; start = 1;
      step();
      start = 0; sel_in = 9; mode = 1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_ch !== 4'd5 || busy !== 1'b1) begin
         errors++;
         $display("FAIL manual_out: valid=%b data=%h ch=%0d busy=%b expected 1 a5 5 1", out_valid, out_data, out_ch, busy);
      end
      step();
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL manual_idle: valid=%b busy=%b expected 0 0", out_valid, busy);
      end
      mode = 0;
   endtask

   task automatic test_scan();
      int n = 0;
      do_reset();
      set_pattern(8'hA0);
      out_ready = 1; mode = 1; start = 1;
      step();
      start = 0;
      for (int c = 1; c <= 120 && n < 16; c++) begin
         step();
         // start/mode/sel_in pulses while busy must have no effect
         if (c == 30) begin start = 1; mode = 0; sel_in = 2; end
         else start = 0;
         if (out_valid) begin
            checks++;
            if (out_ch !== 4'(n) || out_data !== 8'(8'hA0 + n) || c != 4 + 5*n) begin
               errors++;
               $display("FAIL scan_out%0d: ch=%0d data=%h cycle=%0d expected ch=%0d data=%h cycle=%0d", n, out_ch, out_data, c, n, 8'(8'hA0 + n), 4 + 5*n);
            end
            n++;
         end
      end
      start = 0;
      checks++;
      if (n != 16) begin
         errors++;
         $display("FAIL scan_count: got %0d outputs expected 16", n);
      end
      step();
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL scan_done: busy=%b valid=%b expected 0 0", busy, out_valid);
      end
   endtask

   task automatic test_backpressure();
      logic found = 0;
      do_reset();
      set_pattern(8'hA0);
      mode = 1; start = 1;
      step();
      start = 0;
      for (int c = 0; c < 100 && !found; c++) begin
         step();
         if (out_valid && out_ch == 4'd3) found = 1;
         else out_ready = out_valid;
      end
      out_ready = 0;
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL bp_reach_ch3: got no channel 3 output expected one");
      end
      for (int i = 0; i < 10; i++) begin
         set_pattern(8'(8'h11 * i));
         step();
         checks++;
         if (out_valid !== 1'b1 || out_ch !== 4'd3 || out_data !== 8'hA3) begin
            errors++;
            $display("FAIL bp_hold%0d: valid=%b ch=%0d data=%h expected 1 3 a3", i, out_valid, out_ch, out_data);
         end
      end
      set_pattern(8'h50);
      out_ready = 1;
      step();
      found = 0;
      for (int c = 0; c < 20 && !found; c++) begin
         step();
         if (out_valid) found = 1;
      end
      checks++;
      if (!found || out_ch !== 4'd4 || out_data !== 8'h54) begin
         errors++;
         $display("FAIL bp_next: found=%b ch=%0d data=%h expected 1 4 54", found, out_ch, out_data);
      end
   endtask

   task automatic test_reset_mid();
      logic found = 0;
      int   c4 = 0;
      do_reset();
      set_pattern(8'hA0);
      out_ready = 1; mode = 1; start = 1;
      step();
      start = 0;
      for (int c = 0; c < 100 && !found; c++) begin
         step();
         if (out_valid && out_ch == 4'd6) found = 1;
      end
      step();
      step();
      checks++;
      if (!found || busy !== 1'b1 || out_data !== 8'hA6) begin
         errors++;
         $display("FAIL rstmid_pre: found=%b busy=%b data=%h expected 1 1 a6", found, busy, out_data);
      end
      rst_n = 0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || out_data !== 8'h00 || out_ch !== 4'h0) begin
         errors++;
         $display("FAIL rstmid_async: valid=%b busy=%b err=%b data=%h ch=%0d expected all zero", out_valid, busy, err, out_data, out_ch);
      end
      @(negedge clk);
      rst_n = 1; mode = 1; start = 1;
      step();
      start = 0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_first_edge: busy=%b expected 1", busy);
      end
      found = 0;
      for (int c = 1; c <= 20 && !found; c++) begin
         step();
         if (out_valid) begin found = 1; c4 = c; end
      end
      checks++;
      if (!found || out_ch !== 4'd0 || c4 != 4) begin
         errors++;
         $display("FAIL rstmid_restart: found=%b ch=%0d cycle=%0d expected 1 0 4", found, out_ch, c4);
      end
      do_reset();
   endtask

   task automatic test_illegal();
      do_reset();
      set_pattern(8'hA0);
      mode = 0; out_ready = 1;
      for (int s = 12; s <= 13; s++) begin
         sel12 = 4'(s); start12 = 1;
         step();
         start12 = 0;
         checks++;
         if (err12 !== 1'b1 || out_valid12 !== 1'b0 || busy12 !== 1'b0) begin
            errors++;
            $display("FAIL illegal_sel%0d: err=%b valid=%b busy=%b expected 1 0 0", s, err12, out_valid12, busy12);
         end
         step();
         checks++;
         if (err12 !== 1'b0 || out_valid12 !== 1'b0 || busy12 !== 1'b0) begin
            errors++;
            $display("FAIL illegal_after%0d: err=%b valid=%b busy=%b expected 0 0 0", s, err12, out_valid12, busy12);
         end
      end
      sel12 = 4'd11; start12 = 1;
      step();
      start12 = 0;
      checks++;
      if (out_valid12 !== 1'b1 || out_data12 !== 8'hAB || out_ch12 !== 4'd11 || err12 !== 1'b0) begin
         errors++;
         $display("FAIL legal_top12: valid=%b data=%h ch=%0d err=%b expected 1 ab 11 0", out_valid12, out_data12, out_ch12, err12);
      end
      step();
   endtask

`ifdef MUX_SCAN_MASK_EN
   task automatic test_mask();
      logic [3:0] exp_ch [4] = '{4'd0, 4'd5, 4'd10, 4'd15};
      int n = 0;
      logic done = 0;
      do_reset();
      set_pattern(8'hA0);
      ch_mask = 16'h8421; out_ready = 1; mode = 1; start = 1;
      step();
      start = 0;
      for (int c = 0; c < 150 && !done; c++) begin
         step();
         if (out_valid) begin
            checks++;
            if (n >= 4 || out_ch !== exp_ch[n]) begin
               errors++;
               $display("FAIL mask_out%0d: ch=%0d expected %0d", n, out_ch, (n < 4) ? exp_ch[n] : 4'd0);
            end
            n++;
         end
         if (!busy) done = 1;
      end
      checks++;
      if (n != 4 || !done) begin
         errors++;
         $display("FAIL mask_count: got %0d outputs done=%b expected 4 1", n, done);
      end
      ch_mask = 16'h0000; start = 1;
      step();
      start = 0;
      for (int c = 0; c < 6; c++) begin
         checks++;
         if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mask_zero%0d: busy=%b valid=%b expected 0 0", c, busy, out_valid);
         end
         step();
      end
      ch_mask = 16'h8421; mode = 0; sel_in = 4'd1; start = 1;
      step();
      start = 0;
      checks++;
      if (err !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL mask_manual_disabled: err=%b busy=%b valid=%b expected 1 0 0", err, busy, out_valid);
      end
      step();
   endtask
`endif

   initial begin
      data_in = '0;
      test_reset();
      test_manual();
      test_scan();
      test_backpressure();
      test_reset_mid();
      test_illegal();
`ifdef MUX_SCAN_MASK_EN
      test_mask();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
